p12_cfg_loader: RTL and testbench
=================================

Name: p12_cfg_loader

Overview:
- Configuration sequencer for the 8x8 rotating-tile grid.
- Accepts a byte stream of tile configuration bits and serialises it into the grid scan chain one bit per cycle.
- Strobes the vertical, horizontal and diagonal flip latch planes in turn via the 2-bit latch selector.
- Outside configuration, drives the loop-breaker enable and rotates the loop-breaker class on a programmable period.

Parameters:
- CHAIN_LEN, 64, scan-chain length in bits per plane; multiple of 8.
- LB_PERIOD, 16, cycles per loop-breaker class step; >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a full three-plane load; sampled in IDLE only
- cfg_valid  in  1  byte-stream valid
- cfg_data  in  8  configuration byte, shifted MSB first
- cfg_ready  out  1  byte accepted when cfg_valid && cfg_ready
- lb_en  in  1  loop-breaker request while idle
- in_sc  in  1  scan-chain return from the grid (out_sc of grid)
- busy  out  1  high from start acceptance until the cycle after DONE
- done  out  1  one-cycle pulse at completion
- out_se  out  1  grid scan enable
- out_sc  out  1  grid scan data
- out_cfg  out  2  grid latch selector: 0 none, 1 vertical, 2 horizontal, 3 diagonal
- out_lb  out  1  grid loop-breaker enable
- out_lbc  out  2  grid loop-breaker class

Behaviour:
- Reset values:
  - state IDLE; plane 0.
  - busy, done, cfg_ready, out_se, out_sc, out_lb: 0.
  - out_cfg, out_lbc: 0.
  - Bit counter, lb counter and byte buffer cleared; buffer invalid.
- State machine: IDLE -> SHIFT -> LATCH -> (SHIFT for next plane | DONE) -> IDLE.
- IDLE: start=1 -> SHIFT next cycle, plane=0, bit_cnt=0, busy=1. start while busy is ignored.
- SHIFT:
  - 8-bit buffer plus valid flag.
  - cfg_ready = (state==SHIFT) && (!buf_valid || buf_idx==7) && (bytes accepted this plane < CHAIN_LEN/8).
  - Accepted byte loads the buffer and becomes usable the next cycle, so back-to-back valid sustains one bit per cycle.
- Shift cycle:
  - Occurs on every cycle with buf_valid=1: out_se=1, out_sc=buffer[7-buf_idx] (registered outputs), bit_cnt++.
  - With no valid buffer: out_se=0 and out_sc holds, so the chain is frozen during stalls.
- Plane end: after bit_cnt reaches CHAIN_LEN -> LATCH.
- LATCH: exactly one cycle with out_se=0, out_cfg=plane+1. Then out_cfg returns to 0.
  - plane<2: plane++, bit_cnt=0, -> SHIFT.
  - plane==2: -> DONE.
- DONE: done=1 for one cycle, busy drops the following cycle, -> IDLE.
- out_cfg is nonzero only in LATCH. out_se and out_cfg are never simultaneously active.
- Loop breaker:
  - While busy: out_lb=0, out_lbc=0, lb counter cleared.
  - In IDLE with lb_en=1: out_lb=1; lb counter counts 0..LB_PERIOD-1; out_lbc increments mod 4 (3 wraps to 0) when the counter wraps.
  - In IDLE with lb_en=0: out_lb=0, out_lbc and the counter hold.
- Extra cfg_valid outside cfg_ready is ignored, with no data loss or side effects.
- Reset asserted mid-load: all outputs return to reset values immediately (asynchronous). The partial chain contents in the grid are not latched, because out_cfg is forced to 0.
- in_sc is unused unless the optional feature is compiled in.

Optional Feature:
- Macro CFG_READBACK_EN.
- Defined:
  - Adds output rb_crc [7:0], reset 0, cleared on start acceptance.
  - On every shift cycle, in_sc is folded into a CRC-8 (poly 0x07, MSB-first, init 0x00).
  - rb_crc is stable from the DONE cycle until the next start, giving a checksum of the previous configuration shifted out of the grid.
- Undefined: rb_crc absent, in_sc unconnected internally, no CRC logic.

Test Plan:
- Reset then idle with lb_en=0 -> all outputs 0; cfg_ready=0 even with cfg_valid=1.
- start, 24 bytes of 0xA5 with cfg_valid held high (CHAIN_LEN=64):
  - exactly 192 out_se cycles, out_sc pattern 1,0,1,0,0,1,0,1 repeated;
  - out_cfg pulses 1, 2, 3, each exactly one cycle, each after 64 shift cycles;
  - one done pulse; busy low afterwards.
- Same load with cfg_valid toggling every other byte -> identical out_sc bit sequence; out_se=0 during gaps; still 192 shift cycles and three out_cfg pulses.
- Idle, lb_en=1, LB_PERIOD=16 -> out_lb=1; out_lbc steps 0,1,2,3,0 every 16 cycles. Drop lb_en -> out_lbc holds.
- Assert rst_n=0 after 100 shift cycles -> immediate out_se=0, out_cfg=0, busy=0; a subsequent full load completes normally.
- With CFG_READBACK_EN, drive in_sc=1 constantly during a full load -> rb_crc equals the CRC-8/0x07 of 192 one-bits at done; it is cleared to 0 on the next start.

Source files
------------

// File: rtl/p12_cfg_loader.sv
// p12_cfg_loader: configuration sequencer for the 8x8 rotating-tile grid.
// Takes a byte stream of tile configuration bits and shifts it into the grid
// scan chain at one bit per cycle. After each plane it strobes the vertical,
// horizontal and diagonal latch planes in turn. While idle it drives the
// loop-breaker enable and steps the loop-breaker class on a fixed period.
// Optional feature: define CFG_READBACK_EN to add the rb_crc output. rb_crc
// is a CRC-8 (poly 0x07) of the chain contents returned on in_sc during a load.
// All outputs are registered. They lag the internal state by one cycle.
module p12_cfg_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int LB_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_data,
    output logic       cfg_ready,
    input  logic       lb_en,
    input  logic       in_sc,
    output logic       busy,
    output logic       done,
    output logic       out_se,
    output logic       out_sc,
    output logic [1:0] out_cfg,
    output logic       out_lb,
    output logic [1:0] out_lbc
`ifdef CFG_READBACK_EN
    ,
    output logic [7:0] rb_crc
`endif
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int YW = $clog2(CHAIN_LEN / 8 + 1);
    localparam int LW = (LB_PERIOD > 1) ? $clog2(LB_PERIOD) : 1;

    localparam logic [BW-1:0] LAST_BIT        = BW'(CHAIN_LEN - 1);
    localparam logic [YW-1:0] BYTES_PER_PLANE = YW'(CHAIN_LEN / 8);
    localparam logic [LW-1:0] LB_LAST         = LW'(LB_PERIOD - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    plane_q, plane_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [YW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]    buf_q, buf_d;
    logic          buf_valid_q, buf_valid_d;
    logic [2:0]    buf_idx_q, buf_idx_d;
    logic [LW-1:0] lb_cnt_q, lb_cnt_d;

    logic          cfg_ready_q, cfg_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          out_se_q, out_se_d;
    logic          out_sc_q, out_sc_d;
    logic [1:0]    out_cfg_q, out_cfg_d;
    logic          out_lb_q, out_lb_d;
    logic [1:0]    out_lbc_q, out_lbc_d;

    logic          start_s;
    logic          accept_s;
    logic          shift_s;

    // Start is taken only in IDLE after the previous load has fully retired.
    // A byte is taken on the valid/ready handshake. A bit shifts out on each
    // SHIFT cycle that has a full buffer.
    assign start_s  = (state_q == ST_IDLE) && !busy_q && start;
    assign accept_s = cfg_valid && cfg_ready_q;
    assign shift_s  = (state_q == ST_SHIFT) && buf_valid_q;

    // Next-state logic for the sequencer, byte buffer, outputs and loop breaker
    always_comb begin
        state_d     = state_q;
        plane_d     = plane_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        out_se_d    = 1'b0;
        out_sc_d    = out_sc_q;
        out_cfg_d   = 2'd0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d     = ST_SHIFT;
                    plane_d     = 2'd0;
                    bit_cnt_d   = {BW{1'b0}};
                    byte_cnt_d  = {YW{1'b0}};
                    buf_d       = 8'h00;
                    buf_valid_d = 1'b0;
                    buf_idx_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_s) begin
                    out_se_d  = 1'b1;
                    out_sc_d  = buf_q[3'd7 - buf_idx_q];
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    buf_idx_d = buf_idx_q + 3'd1;
                    if (buf_idx_q == 3'd7) begin
                        buf_valid_d = 1'b0;
                    end else begin
                        buf_valid_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_LATCH;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
                // A new byte replaces the buffer as its last bit goes out, so
                // back-to-back bytes keep the chain moving every cycle.
                if (accept_s) begin
                    buf_d       = cfg_data;
                    buf_valid_d = 1'b1;
                    buf_idx_d   = 3'd0;
                    byte_cnt_d  = byte_cnt_q + YW'(1);
                end else begin
                    byte_cnt_d = byte_cnt_d;
                end
            end
            ST_LATCH: begin
                out_cfg_d  = plane_q + 2'd1;
                bit_cnt_d  = {BW{1'b0}};
                byte_cnt_d = {YW{1'b0}};
                if (plane_q == 2'd2) begin
                    state_d = ST_DONE;
                end else begin
                    plane_d = plane_q + 2'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy stays high through the done pulse and drops one cycle later.
        busy_d      = (state_d != ST_IDLE) || done_d;
        cfg_ready_d = (state_d == ST_SHIFT) &&
                      (!buf_valid_d || (buf_idx_d == 3'd7)) &&
                      (byte_cnt_d < BYTES_PER_PLANE);

        if (busy_d) begin
            out_lb_d  = 1'b0;
            out_lbc_d = 2'd0;
            lb_cnt_d  = {LW{1'b0}};
        end else if (lb_en) begin
            out_lb_d = 1'b1;
            if (lb_cnt_q == LB_LAST) begin
                lb_cnt_d  = {LW{1'b0}};
                out_lbc_d = out_lbc_q + 2'd1;
            end else begin
                lb_cnt_d  = lb_cnt_q + LW'(1);
                out_lbc_d = out_lbc_q;
            end
        end else begin
            out_lb_d  = 1'b0;
            out_lbc_d = out_lbc_q;
            lb_cnt_d  = lb_cnt_q;
        end
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            plane_q     <= 2'd0;
            bit_cnt_q   <= {BW{1'b0}};
            byte_cnt_q  <= {YW{1'b0}};
            buf_q       <= 8'h00;
            buf_valid_q <= 1'b0;
            buf_idx_q   <= 3'd0;
            lb_cnt_q    <= {LW{1'b0}};
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_se_q    <= 1'b0;
            out_sc_q    <= 1'b0;
            out_cfg_q   <= 2'd0;
            out_lb_q    <= 1'b0;
            out_lbc_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            plane_q     <= plane_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            lb_cnt_q    <= lb_cnt_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_se_q    <= out_se_d;
            out_sc_q    <= out_sc_d;
            out_cfg_q   <= out_cfg_d;
            out_lb_q    <= out_lb_d;
            out_lbc_q   <= out_lbc_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_se    = out_se_q;
    assign out_sc    = out_sc_q;
    assign out_cfg   = out_cfg_q;
    assign out_lb    = out_lb_q;
    assign out_lbc   = out_lbc_q;

`ifdef CFG_READBACK_EN
    // One MSB-first CRC-8 step, polynomial x^8 + x^2 + x + 1
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_i);
        logic fb;
        fb = crc[7] ^ bit_i;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    logic [7:0] crc_q, crc_d;

    // Fold the returned chain bit in on every shift; restart on a new load
    always_comb begin
        if (start_s) begin
            crc_d = 8'h00;
        end else if (shift_s) begin
            crc_d = crc8_step(crc_q, in_sc);
        end else begin
            crc_d = crc_q;
        end
    end

    // Readback checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign rb_crc = crc_q;
`else
    logic unused_in_sc_s;
    assign unused_in_sc_s = in_sc;
`endif

endmodule

// File: tb/tb_p12_cfg_loader.sv
// Directed self-checking bench for p12_cfg_loader (CHAIN_LEN=64, LB_PERIOD=16).
// Also covers the rb_crc output when CFG_READBACK_EN is defined.
module tb_p12_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       lb_en;
    logic       in_sc;
    logic       busy;
    logic       done;
    logic       out_se;
    logic       out_sc;
    logic [1:0] out_cfg;
    logic       out_lb;
    logic [1:0] out_lbc;
`ifdef CFG_READBACK_EN
    logic [7:0] rb_crc;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] pat [24];
    int se_cnt, sc_err, pulse_cnt, pulse_err, ovl_err, done_cnt, lb_err;
    bit aborted;

    p12_cfg_loader #(.CHAIN_LEN(64), .LB_PERIOD(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .lb_en     (lb_en),
        .in_sc     (in_sc),
        .busy      (busy),
        .done      (done),
        .out_se    (out_se),
        .out_sc    (out_sc),
        .out_cfg   (out_cfg),
        .out_lb    (out_lb),
        .out_lbc   (out_lbc)
`ifdef CFG_READBACK_EN
        ,
        .rb_crc    (rb_crc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

`ifdef CFG_READBACK_EN
    function automatic logic [7:0] crc_ones(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ 1'b1) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    // One full three-plane load of pat[]. gap inserts valid-low bubbles after
    // every other byte. abort_at>0 pulls rst_n after that many shift cycles.
    task automatic run_load(input bit gap, input int abort_at);
        se_cnt = 0; sc_err = 0; pulse_cnt = 0; pulse_err = 0;
        ovl_err = 0; done_cnt = 0; lb_err = 0; aborted = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("busy_start", {31'd0, busy}, 32'd1);
`ifdef CFG_READBACK_EN
        check_eq("crc_clear", {24'd0, rb_crc}, 32'd0);
`endif
        fork
            begin : driver
                int idx, hold, cyc;
                idx = 0; hold = 0; cyc = 0;
                while (idx < 24 && !aborted && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (hold > 0) begin
                        cfg_valid = 1'b0;
                        cfg_data  = 8'h00;
                        hold--;
                    end else begin
                        cfg_valid = 1'b1;
                        cfg_data  = cfg_ready ? pat[idx] : 8'h3C;
                        if (cfg_ready) begin
                            idx++;
                            if (gap && (idx % 2 == 1)) hold = 5;
                        end
                    end
                end
                @(negedge clk);
                cfg_valid = 1'b0;
            end
            begin : monitor
                logic [7:0] b;
                bit fin;
                fin = 1'b0;
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    if (out_se) begin
                        b = pat[se_cnt / 8];
                        if (out_sc !== b[7 - (se_cnt % 8)]) sc_err++;
                        se_cnt++;
                    end
                    if (out_cfg != 2'd0) begin
                        if (out_cfg != 2'(pulse_cnt + 1) || se_cnt != 64 * (pulse_cnt + 1)) pulse_err++;
                        pulse_cnt++;
                    end
                    if (out_se && out_cfg != 2'd0) ovl_err++;
                    if (busy && (out_lb || out_lbc != 2'd0)) lb_err++;
                    if (done) begin
                        done_cnt++;
                        fin = 1'b1;
                    end
                    if (abort_at > 0 && se_cnt == abort_at) begin
                        rst_n = 1'b0;
                        #1;
                        check_eq("abort_se", {31'd0, out_se}, 32'd0);
                        check_eq("abort_cfg", {30'd0, out_cfg}, 32'd0);
                        check_eq("abort_busy", {31'd0, busy}, 32'd0);
                        aborted = 1'b1;
                    end
                    if (fin || aborted) break;
                end
            end
        join
        cfg_valid = 1'b0;
        if (!aborted) begin
            check_eq("se_cnt", se_cnt, 32'd192);
            check_eq("sc_bits", sc_err, 32'd0);
            check_eq("cfg_pulses", pulse_cnt, 32'd3);
            check_eq("cfg_order", pulse_err, 32'd0);
            check_eq("se_cfg_overlap", ovl_err, 32'd0);
            check_eq("lb_busy", lb_err, 32'd0);
            check_eq("done_cnt", done_cnt, 32'd1);
            check_eq("busy_at_done", {31'd0, busy}, 32'd1);
`ifdef CFG_READBACK_EN
            check_eq("crc_done", {24'd0, rb_crc}, {24'd0, crc_ones(192)});
`endif
            @(negedge clk);
            check_eq("busy_after", {31'd0, busy}, 32'd0);
            check_eq("done_once", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int tmp;
        rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        lb_en = 1'b0; in_sc = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset, stray valid must not be accepted
        cfg_valid = 1'b1; cfg_data = 8'hFF;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_ready", {31'd0, cfg_ready}, 32'd0);
        check_eq("rst_se", {31'd0, out_se}, 32'd0);
        check_eq("rst_sc", {31'd0, out_sc}, 32'd0);
        check_eq("rst_cfg", {30'd0, out_cfg}, 32'd0);
        check_eq("rst_lb", {31'd0, out_lb}, 32'd0);
        check_eq("rst_lbc", {30'd0, out_lbc}, 32'd0);
`ifdef CFG_READBACK_EN
        check_eq("rst_crc", {24'd0, rb_crc}, 32'd0);
`endif
        cfg_valid = 1'b0;

        // Load 1: 0xA5 with valid held high
        for (int i = 0; i < 24; i++) pat[i] = 8'hA5;
        run_load(1'b0, 0);

        // Loop breaker: class steps every 16 cycles, holds when lb_en drops
        lb_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1)  check_eq("lb_on", {31'd0, out_lb}, 32'd1);
            if (k == 15) check_eq("lbc_k15", {30'd0, out_lbc}, 32'd0);
            if (k == 16) check_eq("lbc_k16", {30'd0, out_lbc}, 32'd1);
            if (k == 32) check_eq("lbc_k32", {30'd0, out_lbc}, 32'd2);
        end
        lb_en = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("lb_off", {31'd0, out_lb}, 32'd0);
        check_eq("lbc_hold", {30'd0, out_lbc}, 32'd2);
        lb_en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 7)  check_eq("lbc_resume7", {30'd0, out_lbc}, 32'd2);
            if (k == 8)  check_eq("lbc_resume8", {30'd0, out_lbc}, 32'd3);
            if (k == 24) check_eq("lbc_wrap", {30'd0, out_lbc}, 32'd0);
        end

        // Load 2: same data, bubbles in the stream, lb_en left high
        run_load(1'b1, 0);
        lb_en = 1'b0;

        // Load 3: reset during plane 2, then a full load of varied bytes
        for (int i = 0; i < 24; i++) begin
            tmp = i * 29 + 3;
            pat[i] = tmp[7:0];
        end
        run_load(1'b0, 100);
        @(negedge clk);
        rst_n = 1'b1;
        run_load(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
